// File: rtl/fifo.sv
// Single-clock byte FIFO with registered read data, full/empty flags and an
// occupancy count. Writes while full (without a read) and reads while empty
// are silently ignored. Storage is not cleared by reset; only pointers, count
// and the output register are.
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] buff_in,
    output logic [DATA_WIDTH-1:0] buff_out,
    output logic                  full,
    output logic                  empty,
    output logic [7:0]            fifo_count
);

    // Pointer width: DEPTH is a power of two, so pointers wrap naturally.
    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DEPTH_CNT = 8'(DEPTH);

    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [7:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] buff_out_q, buff_out_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_ok;
    logic                  rd_ok;
    logic                  full_w;
    logic                  empty_w;

    // Flags are decoded from the registered count so they move with it.
    assign full_w  = (count_q == DEPTH_CNT);
    assign empty_w = (count_q == 8'd0);

    // Accept rules: a write into a full FIFO is allowed only when a read frees
    // a slot on the same edge; a read of an empty FIFO never falls through.
    always_comb begin
        wr_ok = write && (!full_w || read);
        rd_ok = read && !empty_w;
    end

    // Next-state for pointers, count and the read-data register.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        buff_out_d = buff_out_q;

        if (wr_ok) begin
            wptr_d = wptr_q + AW'(1);
        end

        if (rd_ok) begin
            rptr_d     = rptr_q + AW'(1);
            buff_out_d = mem_q[rptr_q];
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 8'd1;
            2'b01:   count_d = count_q - 8'd1;
            default: count_d = count_q;
        endcase
    end

    // Control and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= 8'd0;
            buff_out_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            buff_out_q <= buff_out_d;
        end
    end

    // Storage array: written only on an accepted write, never reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wptr_q] <= buff_in;
        end
    end

    assign buff_out   = buff_out_q;
    assign full       = full_w;
    assign empty      = empty_w;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: the driver updates a queue-based reference model
// and pushes the expected post-edge outputs; a monitor branch pops and compares.
module tb_fifo;

    localparam int DEPTH = 64;

    logic       clk;
    logic       reset;
    logic       read;
    logic       write;
    logic [7:0] buff_in;
    logic [7:0] buff_out;
    logic       full;
    logic       empty;
    logic [7:0] fifo_count;

    fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .buff_in   (buff_in),
        .buff_out  (buff_out),
        .full      (full),
        .empty     (empty),
        .fifo_count(fifo_count)
    );

    typedef struct {
        int         due;
        logic [7:0] out;
        int         cnt;
        bit         fl;
        bit         em;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] model[$];
    logic [7:0] last_out;
    int         cyc;
    int         total;
    int         bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // One clock of stimulus; called on a falling edge, returns on the next one.
    task automatic step(input bit rd, input bit wr, input logic [7:0] d);
        bit   wok;
        bit   rok;
        exp_t e;
        read    = rd;
        write   = wr;
        buff_in = d;
        wok = wr && ((model.size() != DEPTH) || rd);
        rok = rd && (model.size() != 0);
        if (rok) last_out = model.pop_front();
        if (wok) model.push_back(d);
        e.due = cyc + 1;
        e.out = last_out;
        e.cnt = model.size();
        e.fl  = (model.size() == DEPTH);
        e.em  = (model.size() == 0);
        expq.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        cyc      = 0;
        total    = 0;
        bad      = 0;
        last_out = 8'h00;
        reset    = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
        buff_in  = 8'h00;
        fork
            begin : monitor
                forever begin
                    exp_t e;
                    @(negedge clk);
                    #1;
                    while (expq.size() > 0 && expq[0].due <= cyc) begin
                        e = expq.pop_front();
                        chk("buff_out", int'(buff_out), int'(e.out));
                        chk("fifo_count", int'(fifo_count), e.cnt);
                        chk("full", int'(full), int'(e.fl));
                        chk("empty", int'(empty), int'(e.em));
                    end
                end
            end
            begin : stimulus
                logic [7:0] pat[5];
                pat = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0d};

                // Reset held from time zero.
                #10;
                chk("rst_count", int'(fifo_count), 0);
                chk("rst_empty", int'(empty), 1);
                chk("rst_full", int'(full), 0);
                chk("rst_buff_out", int'(buff_out), 0);
                reset = 1'b1;
                for (int i = 0; i < 3; i++) step(0, 0, 8'h00);

                // Five writes, then six reads (last one on an empty FIFO).
                for (int i = 0; i < 5; i++) step(0, 1, pat[i]);
                for (int i = 0; i < 6; i++) step(1, 0, 8'h00);

                // Fill, overflow attempt, drain.
                for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i));
                step(0, 1, 8'hff);
                for (int i = 0; i < DEPTH; i++) step(1, 0, 8'h00);
                step(1, 0, 8'h00);

                // Simultaneous read+write at count 3, empty, and full.
                for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h40 + i));
                step(1, 1, 8'h50);
                for (int i = 0; i < 3; i++) step(1, 0, 8'h00);
                step(1, 1, 8'h51);
                for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 8'(8'h80 + i));
                step(1, 1, 8'hee);
                step(1, 1, 8'hef);
                for (int i = 0; i < DEPTH; i++) step(1, 0, 8'h00);

                // Pointer wrap.
                for (int i = 0; i < 60; i++) step(0, 1, 8'(i * 3));
                for (int i = 0; i < 60; i++) step(1, 0, 8'h00);
                for (int i = 0; i < 10; i++) step(0, 1, 8'(8'hc0 + i));
                for (int i = 0; i < 10; i++) step(1, 0, 8'h00);

                // Randomized traffic with varying write/read bias.
                for (int seg = 0; seg < 4; seg++) begin
                    int wp;
                    wp = (seg == 0) ? 70 : (seg == 1) ? 30 : (seg == 2) ? 90 : 50;
                    for (int i = 0; i < 400; i++) begin
                        step(bit'($urandom_range(0, 99) >= wp),
                             bit'($urandom_range(0, 99) < wp),
                             8'($urandom));
                    end
                end

                // Leave data in flight, then reset between clock edges.
                for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h11 * (i + 1)));
                step(1, 0, 8'h00);
                read  = 1'b0;
                write = 1'b0;
                #3;
                chk("queue_drained", expq.size(), 0);
                reset = 1'b0;
                #1;
                chk("async_rst_count", int'(fifo_count), 0);
                chk("async_rst_empty", int'(empty), 1);
                chk("async_rst_full", int'(full), 0);
                chk("async_rst_buff_out", int'(buff_out), 0);
                model.delete();
                last_out = 8'h00;
                @(negedge clk);
                reset = 1'b1;
                step(0, 1, 8'h5a);
                step(0, 1, 8'ha5);
                step(1, 0, 8'h00);
                step(1, 0, 8'h00);
                step(0, 0, 8'h00);
                step(0, 0, 8'h00);
                #3;
                chk("final_queue_drained", expq.size(), 0);

                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        join_any
    end

endmodule
